// File: rtl/address_gen3.sv
`default_nettype none
// ============================================================================
// Module   : address_gen3
// Purpose  : Six-level nested address generator. Emits
//            per*iter*per2*iter2*per3*iter3 addresses starting at start_i;
//            after each consumed element exactly one step term is added,
//            chosen by the innermost counter that has not reached its last
//            value. store_o flags elements whose level-1 index is inside
//            the duty window.
// Ports    : clk_i, rst_i (async, active high)
//            run_i          start / restart pulse, samples all config inputs
//            ignore_first_i consume the first element internally
//            ready_i        consumer ready (valid_o && ready_i consumes)
//            start_i, delay_i, per_i, duty_i, iter_i, incr_i, shift_i,
//            per2_i, iter2_i, incr2_i, shift2_i,
//            per3_i, iter3_i, incr3_i, shift3_i   configuration
//            valid_o, addr_o, store_o, done_o     element stream / status
// Revision : 1.0 - initial release
// ============================================================================
module address_gen3 #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int DELAY_W  = 7,
    parameter int PERIOD_W = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic                ignore_first_i,
    input  logic                ready_i,
    input  logic [ADDR_W-1:0]   start_i,
    input  logic [DELAY_W-1:0]  delay_i,
    input  logic [PERIOD_W-1:0] per_i,
    input  logic [PERIOD_W-1:0] duty_i,
    input  logic [ADDR_W-1:0]   iter_i,
    input  logic [ADDR_W-1:0]   incr_i,
    input  logic [ADDR_W-1:0]   shift_i,
    input  logic [PERIOD_W-1:0] per2_i,
    input  logic [ADDR_W-1:0]   iter2_i,
    input  logic [ADDR_W-1:0]   incr2_i,
    input  logic [ADDR_W-1:0]   shift2_i,
    input  logic [PERIOD_W-1:0] per3_i,
    input  logic [ADDR_W-1:0]   iter3_i,
    input  logic [ADDR_W-1:0]   incr3_i,
    input  logic [ADDR_W-1:0]   shift3_i,
    output logic                valid_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                store_o,
    output logic                done_o
);

    // DATA_W has no datapath role; it is only sanity-checked at elaboration.
    if (DATA_W < 1) begin : g_chk_data_w
        $error("address_gen3: DATA_W must be positive");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        GEN   = 2'd2
    } state_t;

    state_t              state_q;
    logic                valid_q, store_q, done_q, empty_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DELAY_W-1:0]  dly_q;

    // Latched configuration
    logic [PERIOD_W-1:0] per_q, duty_q, per2_q, per3_q;
    logic [ADDR_W-1:0]   iter_q, incr_q, shift_q;
    logic [ADDR_W-1:0]   iter2_q, incr2_q, shift2_q;
    logic [ADDR_W-1:0]   iter3_q, incr3_q, shift3_q;

    // Counters, innermost (f) to outermost (a)
    logic [PERIOD_W-1:0] cnt_f_q, cnt_d_q, cnt_b_q;
    logic [ADDR_W-1:0]   cnt_e_q, cnt_c_q, cnt_a_q;

    // The advance logic runs on live inputs during run_i so that an
    // ignored first element can be skipped in the same cycle as the start,
    // and on the registered state otherwise.
    logic [PERIOD_W-1:0] per_s, duty_s, per2_s, per3_s;
    logic [ADDR_W-1:0]   iter_s, incr_s, shift_s, iter2_s, incr2_s, shift2_s;
    logic [ADDR_W-1:0]   iter3_s, incr3_s, shift3_s, addr_s;
    logic [PERIOD_W-1:0] cnt_f_s, cnt_d_s, cnt_b_s;
    logic [ADDR_W-1:0]   cnt_e_s, cnt_c_s, cnt_a_s;

    assign per_s    = run_i ? per_i    : per_q;
    assign duty_s   = run_i ? duty_i   : duty_q;
    assign per2_s   = run_i ? per2_i   : per2_q;
    assign per3_s   = run_i ? per3_i   : per3_q;
    assign iter_s   = run_i ? iter_i   : iter_q;
    assign incr_s   = run_i ? incr_i   : incr_q;
    assign shift_s  = run_i ? shift_i  : shift_q;
    assign iter2_s  = run_i ? iter2_i  : iter2_q;
    assign incr2_s  = run_i ? incr2_i  : incr2_q;
    assign shift2_s = run_i ? shift2_i : shift2_q;
    assign iter3_s  = run_i ? iter3_i  : iter3_q;
    assign incr3_s  = run_i ? incr3_i  : incr3_q;
    assign shift3_s = run_i ? shift3_i : shift3_q;
    assign addr_s   = run_i ? start_i  : addr_q;
    assign cnt_f_s  = run_i ? '0 : cnt_f_q;
    assign cnt_e_s  = run_i ? '0 : cnt_e_q;
    assign cnt_d_s  = run_i ? '0 : cnt_d_q;
    assign cnt_c_s  = run_i ? '0 : cnt_c_q;
    assign cnt_b_s  = run_i ? '0 : cnt_b_q;
    assign cnt_a_s  = run_i ? '0 : cnt_a_q;

    // A configured count of zero behaves as a count of one.
    function automatic logic is_last_p(input logic [PERIOD_W-1:0] cnt,
                                       input logic [PERIOD_W-1:0] n);
        logic [PERIOD_W-1:0] n_eff;
        n_eff = (n == '0) ? PERIOD_W'(1) : n;
        return cnt == (n_eff - PERIOD_W'(1));
    endfunction

    function automatic logic is_last_a(input logic [ADDR_W-1:0] cnt,
                                       input logic [ADDR_W-1:0] n);
        logic [ADDR_W-1:0] n_eff;
        n_eff = (n == '0) ? ADDR_W'(1) : n;
        return cnt == (n_eff - ADDR_W'(1));
    endfunction

    logic [PERIOD_W-1:0] cnt_f_d, cnt_d_d, cnt_b_d;
    logic [ADDR_W-1:0]   cnt_e_d, cnt_c_d, cnt_a_d, addr_d;
    logic                store_d, last_w;

    always_comb begin
        cnt_f_d = cnt_f_s;
        cnt_e_d = cnt_e_s;
        cnt_d_d = cnt_d_s;
        cnt_c_d = cnt_c_s;
        cnt_b_d = cnt_b_s;
        cnt_a_d = cnt_a_s;
        addr_d  = addr_s;
        last_w  = 1'b0;
        if (!is_last_p(cnt_f_s, per_s)) begin
            cnt_f_d = cnt_f_s + PERIOD_W'(1);
            addr_d  = addr_s + incr_s;
        end else if (!is_last_a(cnt_e_s, iter_s)) begin
            cnt_f_d = '0;
            cnt_e_d = cnt_e_s + ADDR_W'(1);
            addr_d  = addr_s + shift_s;
        end else if (!is_last_p(cnt_d_s, per2_s)) begin
            cnt_f_d = '0;
            cnt_e_d = '0;
            cnt_d_d = cnt_d_s + PERIOD_W'(1);
            addr_d  = addr_s + incr2_s;
        end else if (!is_last_a(cnt_c_s, iter2_s)) begin
            cnt_f_d = '0;
            cnt_e_d = '0;
            cnt_d_d = '0;
            cnt_c_d = cnt_c_s + ADDR_W'(1);
            addr_d  = addr_s + shift2_s;
        end else if (!is_last_p(cnt_b_s, per3_s)) begin
            cnt_f_d = '0;
            cnt_e_d = '0;
            cnt_d_d = '0;
            cnt_c_d = '0;
            cnt_b_d = cnt_b_s + PERIOD_W'(1);
            addr_d  = addr_s + incr3_s;
        end else if (!is_last_a(cnt_a_s, iter3_s)) begin
            cnt_f_d = '0;
            cnt_e_d = '0;
            cnt_d_d = '0;
            cnt_c_d = '0;
            cnt_b_d = '0;
            cnt_a_d = cnt_a_s + ADDR_W'(1);
            addr_d  = addr_s + shift3_s;
        end else begin
            last_w = 1'b1;
        end
    end

    // duty >= per naturally yields 1 for every f < per.
    assign store_d = (duty_s == '0) || (cnt_f_d < duty_s);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            store_q  <= 1'b0;
            done_q   <= 1'b1;
            empty_q  <= 1'b0;
            addr_q   <= '0;
            dly_q    <= '0;
            per_q    <= '0;  duty_q   <= '0;  per2_q   <= '0;  per3_q   <= '0;
            iter_q   <= '0;  incr_q   <= '0;  shift_q  <= '0;
            iter2_q  <= '0;  incr2_q  <= '0;  shift2_q <= '0;
            iter3_q  <= '0;  incr3_q  <= '0;  shift3_q <= '0;
            cnt_f_q  <= '0;  cnt_e_q  <= '0;  cnt_d_q  <= '0;
            cnt_c_q  <= '0;  cnt_b_q  <= '0;  cnt_a_q  <= '0;
        end else if (run_i) begin
            // run_i wins over any handshake in the same cycle.
            per_q    <= per_i;   duty_q   <= duty_i;
            per2_q   <= per2_i;  per3_q   <= per3_i;
            iter_q   <= iter_i;  incr_q   <= incr_i;  shift_q  <= shift_i;
            iter2_q  <= iter2_i; incr2_q  <= incr2_i; shift2_q <= shift2_i;
            iter3_q  <= iter3_i; incr3_q  <= incr3_i; shift3_q <= shift3_i;
            dly_q    <= delay_i;
            done_q   <= 1'b0;
            if (ignore_first_i && !last_w) begin
                cnt_f_q <= cnt_f_d;  cnt_e_q <= cnt_e_d;  cnt_d_q <= cnt_d_d;
                cnt_c_q <= cnt_c_d;  cnt_b_q <= cnt_b_d;  cnt_a_q <= cnt_a_d;
                addr_q  <= addr_d;
                store_q <= store_d;
                empty_q <= 1'b0;
            end else begin
                cnt_f_q <= '0;  cnt_e_q <= '0;  cnt_d_q <= '0;
                cnt_c_q <= '0;  cnt_b_q <= '0;  cnt_a_q <= '0;
                addr_q  <= start_i;
                store_q <= 1'b1;   // f = 0 is always inside the duty window
                // A single-element sequence with ignore_first has nothing to show.
                empty_q <= ignore_first_i;
            end
            if (delay_i == '0) begin
                state_q <= GEN;
                valid_q <= !(ignore_first_i && last_w);
            end else begin
                state_q <= DELAY;
                valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                DELAY: begin
                    dly_q <= dly_q - DELAY_W'(1);
                    if (dly_q == DELAY_W'(1)) begin
                        state_q <= GEN;
                        valid_q <= !empty_q;
                    end
                end
                GEN: begin
                    if (!valid_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (ready_i) begin
                        if (last_w) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_f_q <= cnt_f_d;  cnt_e_q <= cnt_e_d;
                            cnt_d_q <= cnt_d_d;  cnt_c_q <= cnt_c_d;
                            cnt_b_q <= cnt_b_d;  cnt_a_q <= cnt_a_d;
                            addr_q  <= addr_d;
                            store_q <= store_d;
                        end
                    end
                end
                IDLE: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign store_o = store_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_address_gen3.sv
`default_nettype none
// ============================================================================
// Module   : tb_address_gen3
// Purpose  : Self-checking bench for address_gen3: directed vector table,
//            hand-written multi-cycle sequences and randomized runs checked
//            against a closed-form (mixed-radix stride) reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_address_gen3;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int DELAY_W  = 7;
    localparam int PERIOD_W = 10;
    localparam int MASK     = (1 << ADDR_W) - 1;

    logic clk = 1'b0;
    logic rst_i, run_i, ignore_first_i, ready_i;
    logic [ADDR_W-1:0]   start_i, iter_i, incr_i, shift_i;
    logic [ADDR_W-1:0]   iter2_i, incr2_i, shift2_i, iter3_i, incr3_i, shift3_i;
    logic [DELAY_W-1:0]  delay_i;
    logic [PERIOD_W-1:0] per_i, duty_i, per2_i, per3_i;
    logic                valid_o, store_o, done_o;
    logic [ADDR_W-1:0]   addr_o;

    always #5 clk = ~clk;

    address_gen3 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DELAY_W(DELAY_W),
                   .PERIOD_W(PERIOD_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .run_i(run_i),
        .ignore_first_i(ignore_first_i), .ready_i(ready_i),
        .start_i(start_i), .delay_i(delay_i), .per_i(per_i), .duty_i(duty_i),
        .iter_i(iter_i), .incr_i(incr_i), .shift_i(shift_i),
        .per2_i(per2_i), .iter2_i(iter2_i), .incr2_i(incr2_i), .shift2_i(shift2_i),
        .per3_i(per3_i), .iter3_i(iter3_i), .incr3_i(incr3_i), .shift3_i(shift3_i),
        .valid_o(valid_o), .addr_o(addr_o), .store_o(store_o), .done_o(done_o)
    );

    typedef struct packed {
        int start; int delay; int per; int duty; int iter; int incr; int shift;
        int per2; int iter2; int incr2; int shift2;
        int per3; int iter3; int incr3; int shift3; int ign;
    } cfg_t;

    typedef struct packed {
        cfg_t              cfg;
        int                n;
        logic [0:7][15:0]  addr;
        logic [0:7]        store;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    int exp_addr[$];
    int exp_store[$];
    vec_t vecs[4];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic cfg_t mk(input int start, input int per, input int incr);
        cfg_t c;
        c = '0;
        c.start = start;
        c.per   = per;
        c.incr  = incr;
        return c;
    endfunction

    task automatic start_run(input cfg_t c);
        start_i  = ADDR_W'(c.start);   delay_i  = DELAY_W'(c.delay);
        per_i    = PERIOD_W'(c.per);   duty_i   = PERIOD_W'(c.duty);
        iter_i   = ADDR_W'(c.iter);    incr_i   = ADDR_W'(c.incr);
        shift_i  = ADDR_W'(c.shift);   per2_i   = PERIOD_W'(c.per2);
        iter2_i  = ADDR_W'(c.iter2);   incr2_i  = ADDR_W'(c.incr2);
        shift2_i = ADDR_W'(c.shift2);  per3_i   = PERIOD_W'(c.per3);
        iter3_i  = ADDR_W'(c.iter3);   incr3_i  = ADDR_W'(c.incr3);
        shift3_i = ADDR_W'(c.shift3);  ignore_first_i = c.ign[0];
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        ignore_first_i = 1'b0;
        chk("done_low_after_run", int'(done_o), 0);
    endtask

    // Cycles counted from the cycle in which run_i was sampled.
    task automatic wait_valid(input int exp_lat);
        int n = 1;
        while (!valid_o && n < 300) begin
            step();
            n++;
        end
        chk("first_valid_latency", n, exp_lat);
    endtask

    // Closed form: address = start + sum(idx_k * stride_k) where each level's
    // stride is its own step plus the distance the inner levels have walked.
    task automatic build_model(input cfg_t c);
        int n[6], t[6], s[6];
        int total, rem, idx, a, f;
        n[0] = (c.per   == 0) ? 1 : c.per;
        n[1] = (c.iter  == 0) ? 1 : c.iter;
        n[2] = (c.per2  == 0) ? 1 : c.per2;
        n[3] = (c.iter2 == 0) ? 1 : c.iter2;
        n[4] = (c.per3  == 0) ? 1 : c.per3;
        n[5] = (c.iter3 == 0) ? 1 : c.iter3;
        t[0] = c.incr;  t[1] = c.shift;  t[2] = c.incr2;
        t[3] = c.shift2; t[4] = c.incr3; t[5] = c.shift3;
        for (int k = 0; k < 6; k++) begin
            s[k] = t[k];
            for (int j = 0; j < k; j++) s[k] = (s[k] + (n[j] - 1) * s[j]) & MASK;
        end
        total = 1;
        for (int k = 0; k < 6; k++) total *= n[k];
        exp_addr.delete();
        exp_store.delete();
        for (int i = 0; i < total; i++) begin
            rem = i;
            a = c.start;
            f = 0;
            for (int k = 0; k < 6; k++) begin
                idx = rem % n[k];
                rem = rem / n[k];
                if (k == 0) f = idx;
                a = (a + idx * s[k]) & MASK;
            end
            exp_addr.push_back(a);
            exp_store.push_back((c.duty == 0 || f < c.duty) ? 1 : 0);
        end
        if (c.ign != 0) begin
            void'(exp_addr.pop_front());
            void'(exp_store.pop_front());
        end
    endtask

    int pat_rdy[6]  = '{1, 0, 0, 1, 1, 1};
    int pat_addr[6] = '{5, 6, 6, 6, 7, 8};

    initial begin
        cfg_t c;
        int cyc;
        bit took;

        rst_i = 1'b1; run_i = 1'b0; ignore_first_i = 1'b0; ready_i = 1'b1;
        c = '0;
        start_i = '0; delay_i = '0; per_i = '0; duty_i = '0; iter_i = '0;
        incr_i = '0; shift_i = '0; per2_i = '0; iter2_i = '0; incr2_i = '0;
        shift2_i = '0; per3_i = '0; iter3_i = '0; incr3_i = '0; shift3_i = '0;

        // Directed vector table
        vecs[0].cfg = mk(5, 4, 1);
        vecs[0].n = 4;
        vecs[0].addr = {16'd5, 16'd6, 16'd7, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[0].store = 8'b1111_0000;
        c = mk(0, 3, 1); c.iter = 2; c.shift = 10;
        vecs[1].cfg = c;
        vecs[1].n = 6;
        vecs[1].addr = {16'd0, 16'd1, 16'd2, 16'd12, 16'd13, 16'd14, 16'd0, 16'd0};
        vecs[1].store = 8'b1111_1100;
        c = mk(0, 4, 1); c.duty = 2; c.iter = 1; c.per2 = 2; c.incr2 = 100;
        vecs[2].cfg = c;
        vecs[2].n = 8;
        vecs[2].addr = {16'd0, 16'd1, 16'd2, 16'd3, 16'd103, 16'd104, 16'd105, 16'd106};
        vecs[2].store = 8'b1100_1100;
        c = mk(0, 3, 1); c.delay = 3; c.ign = 1;
        vecs[3].cfg = c;
        vecs[3].n = 2;
        vecs[3].addr = {16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[3].store = 8'b1100_0000;

        // Reset state
        step(); step();
        chk("reset_done", int'(done_o), 1);
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_addr", int'(addr_o), 0);
        chk("reset_store", int'(store_o), 0);
        rst_i = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            ready_i = 1'b1;
            start_run(vecs[v].cfg);
            wait_valid(vecs[v].cfg.delay + 1);
            for (int i = 0; i < vecs[v].n; i++) begin
                chk($sformatf("vec%0d_valid%0d", v, i), int'(valid_o), 1);
                chk($sformatf("vec%0d_addr%0d", v, i), int'(addr_o), int'(vecs[v].addr[i]));
                chk($sformatf("vec%0d_store%0d", v, i), int'(store_o), int'(vecs[v].store[i]));
                step();
            end
            chk($sformatf("vec%0d_done", v), int'(done_o), 1);
            chk($sformatf("vec%0d_valid_end", v), int'(valid_o), 0);
            chk($sformatf("vec%0d_addr_hold", v), int'(addr_o),
                int'(vecs[v].addr[vecs[v].n-1]));
            step();
        end

        // Back-pressure: address held while ready is low, nothing skipped
        ready_i = 1'b1;
        start_run(mk(5, 4, 1));
        wait_valid(1);
        for (int i = 0; i < 6; i++) begin
            ready_i = pat_rdy[i][0];
            chk($sformatf("bp_valid%0d", i), int'(valid_o), 1);
            chk($sformatf("bp_addr%0d", i), int'(addr_o), pat_addr[i]);
            step();
        end
        chk("bp_done", int'(done_o), 1);
        step();

        // Restart while busy, run_i beating a same-cycle handshake
        ready_i = 1'b1;
        start_run(mk(5, 4, 1));
        step(); step();
        chk("abort_pre_addr", int'(addr_o), 7);
        start_run(mk(50, 2, 1));
        chk("abort_valid", int'(valid_o), 1);
        chk("abort_addr0", int'(addr_o), 50);
        step();
        chk("abort_addr1", int'(addr_o), 51);
        step();
        chk("abort_done", int'(done_o), 1);

        // Asynchronous reset mid-sequence
        start_run(mk(5, 4, 1));
        step();
        chk("rst_mid_pre_addr", int'(addr_o), 6);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid_done", int'(done_o), 1);
        chk("rst_mid_valid", int'(valid_o), 0);
        step();
        rst_i = 1'b0;
        step(); step();
        chk("rst_mid_quiet", int'(valid_o), 0);
        start_run(mk(5, 4, 1));
        wait_valid(1);
        chk("rst_restart_addr", int'(addr_o), 5);
        step(); step(); step(); step();
        chk("rst_restart_done", int'(done_o), 1);

        // Randomized runs against the reference model
        for (int r = 0; r < 30; r++) begin
            c = '0;
            c.start = $urandom_range(0, MASK);
            c.delay = $urandom_range(0, 4);
            c.per   = $urandom_range(0, 4);
            c.duty  = $urandom_range(0, 5);
            c.iter  = $urandom_range(0, 3);
            c.incr  = $urandom_range(0, MASK);
            c.shift = $urandom_range(0, MASK);
            c.per2  = $urandom_range(0, 2);
            c.iter2 = $urandom_range(0, 2);
            c.incr2 = $urandom_range(0, MASK);
            c.shift2 = $urandom_range(0, MASK);
            c.per3  = $urandom_range(0, 2);
            c.iter3 = $urandom_range(0, 2);
            c.incr3 = $urandom_range(0, MASK);
            c.shift3 = $urandom_range(0, MASK);
            c.ign   = $urandom_range(0, 1);
            build_model(c);
            if (exp_addr.size() == 0) begin
                c.ign = 0;
                build_model(c);
            end
            ready_i = 1'b1;
            start_run(c);
            wait_valid(c.delay + 1);
            cyc = 0;
            while (exp_addr.size() > 0 && cyc < 3000) begin
                ready_i = ($urandom_range(0, 3) != 0);
                chk($sformatf("rnd%0d_valid", r), int'(valid_o), 1);
                if (valid_o) begin
                    chk($sformatf("rnd%0d_addr", r), int'(addr_o), exp_addr[0]);
                    chk($sformatf("rnd%0d_store", r), int'(store_o), exp_store[0]);
                end
                took = valid_o && ready_i;
                step();
                if (took) begin
                    void'(exp_addr.pop_front());
                    void'(exp_store.pop_front());
                end
                cyc++;
            end
            chk($sformatf("rnd%0d_remaining", r), exp_addr.size(), 0);
            chk($sformatf("rnd%0d_done", r), int'(done_o), 1);
            chk($sformatf("rnd%0d_valid_end", r), int'(valid_o), 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/address_gen3.md
ADDRESS_GEN3 -- requirements
Module: AddressGen3

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, address and iteration width.
REQ-002 SHALL have parameter DATA_W, default 32, which is unused and kept for port compatibility.
REQ-003 SHALL have parameter DELAY_W, default 7, the width of delay_i.
REQ-004 SHALL have parameter PERIOD_W, default 10, the width of the per and duty inputs.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, named as the codebase does:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
REQ-006 SHALL have these control ports:
- run_i  in  1  start pulse.
- ignore_first_i  in  1  suppress the first element.
- ready_i  in  1  consumer ready.
REQ-007 SHALL have these config ports, sampled only on run_i:
- start_i  in  ADDR_W  first address.
- delay_i  in  DELAY_W  start delay in cycles.
- per_i, duty_i  in  PERIOD_W  level-1 period and duty.
- iter_i, incr_i, shift_i  in  ADDR_W  level-1 iterations, step and shift.
REQ-008 SHALL have these outer-level config ports, also sampled only on run_i:
- per2_i, per3_i  in  PERIOD_W  level-2 and level-3 periods.
- iter2_i, incr2_i, shift2_i  in  ADDR_W  level-2 iterations, step and shift.
- iter3_i, incr3_i, shift3_i  in  ADDR_W  level-3 iterations, step and shift.
REQ-009 SHALL have these outputs:
- valid_o  out  1  element valid.
- addr_o  out  ADDR_W  element address.
- store_o  out  1  element is within duty.
- done_o  out  1  idle/finished.

Function
REQ-010 SHALL generate six nested counters, innermost first: f<per, e<iter, d<per2, c<iter2, b<per3, a<iter3; any count of 0 SHALL be treated as 1.
REQ-011 SHALL emit exactly per·iter·per2·iter2·per3·iter3 elements, with the first element's address equal to start_i.
REQ-012 SHALL update the address after each consumed element by exactly one term, chosen by priority:
- f not last: +incr.
- else e not last: +shift.
- else d not last: +incr2.
- else c not last: +shift2.
- else b not last: +incr3.
- else a not last: +shift3.
- else the sequence ends.
REQ-013 SHALL perform address arithmetic modulo 2^ADDR_W, so values with the top bit set act as negative two's-complement steps.
REQ-014 SHALL drive store_o=1 iff f<duty; duty=0 or duty≥per SHALL give store_o=1 for every element.
REQ-015 SHALL consume an element (advance the counters) only in a cycle where valid_o && ready_i; addr_o and store_o SHALL stay stable while valid_o=1 and ready_i=0.
REQ-016 SHALL assert valid_o for the first element exactly delay_i+1 cycles after the cycle in which run_i is sampled high; delay_i=0 gives the next cycle.
REQ-017 With ignore_first_i=1, the first element SHALL be consumed internally without asserting valid_o and the counters SHALL advance regardless of ready_i; valid_o SHALL then present the second element on the next cycle.
REQ-018 SHALL drop done_o on the cycle after run_i and raise it on the cycle after the final element is consumed; valid_o SHALL be 0 from that cycle onward.
REQ-019 run_i while busy SHALL abort the current sequence and restart it with the newly sampled configuration; run_i SHALL have priority over a same-cycle handshake.
REQ-020 When idle (done_o=1), valid_o SHALL be 0 and addr_o SHALL hold its last value.
REQ-021 Scope: one FSM with states IDLE, DELAY, GEN; six counters; one address accumulator; no memory.

Reset
REQ-022 On rst_i, asynchronously: done_o=1, valid_o=0, store_o=0, addr_o=0, all counters 0, state IDLE.
REQ-023 Reset asserted mid-sequence SHALL abort the sequence immediately; no element SHALL be emitted until the next run_i.

Verification
REQ-024 SHALL be covered: start=5, per=4, incr=1, all other config 0, delay=0, ready=1 -> addr 5,6,7,8 on 4 consecutive cycles starting 1 cycle after run; done_o high the cycle after the last element.
REQ-025 SHALL be covered: per=3, iter=2, incr=1, shift=10 -> addr 0,1,2,12,13,14.
REQ-026 SHALL be covered: per=4, duty=2 -> store_o 1,1,0,0; then per2=2, incr2=100, iter=1 -> level-1 block repeated starting at addr 3+100=103 relative to start 0 with incr=1.
REQ-027 SHALL be covered: delay=3, ignore_first=1, per=3, incr=1 -> first valid_o 4 cycles after run, presenting addr 1; then addr 2.
REQ-028 SHALL be covered: ready_i toggling 1,0,0,1 -> addr held while ready=0, no element skipped or duplicated.
REQ-029 SHALL be covered: rst_i asserted mid-sequence -> done_o=1 and valid_o=0 immediately; a following run_i restarts from start_i.
